// File: rtl/edsac_loader_if.sv
// Byte-stream and word-memory signals shared by the loader and its neighbours.
// The master side is the loader: it consumes bytes and issues memory writes.
interface edsac_loader_if #(
  parameter int ABITS = 9
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [ABITS-1:0] mem_addr;
  logic [15:0]      mem_d;
  logic             mem_wr;
  logic             mem_rd;
  logic             mem_wait;

  modport master (
    input  rx_data, rx_valid, mem_wait,
    output rx_ready, mem_addr, mem_d, mem_wr, mem_rd
  );

  modport slave (
    output rx_data, rx_valid, mem_wait,
    input  rx_ready, mem_addr, mem_d, mem_wr, mem_rd
  );
endinterface

// File: rtl/edsac_loader.sv
// Packs little-endian byte pairs into 16-bit words and writes NWORDS words from address 0,
// keeping a mod-2^16 running checksum of the words written.
module edsac_loader #(
  parameter int ABITS  = 9,
  parameter int NWORDS = 512
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                abort,
  edsac_loader_if.master      bus,
  output logic                busy,
  output logic                done,
  output logic [15:0]         checksum
);

  localparam logic [ABITS-1:0] LAST_ADDR = ABITS'(NWORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LO    = 3'd1,
    S_HI    = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic   abort_pend;
  logic   write_fin;

  function automatic logic [15:0] wrap_add16(input logic [15:0] a, input logic [15:0] b);
    return a + b;
  endfunction

  assign write_fin = (state == S_WRITE) && !bus.mem_wait;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.rx_ready = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.mem_rd   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        if (!abort && start) state_nxt = S_LO;
      end
      S_LO: begin
        bus.rx_ready = 1'b1;
        busy         = 1'b1;
        if (abort)             state_nxt = S_IDLE;
        else if (bus.rx_valid) state_nxt = S_HI;
      end
      S_HI: begin
        bus.rx_ready = 1'b1;
        busy         = 1'b1;
        if (abort)             state_nxt = S_IDLE;
        else if (bus.rx_valid) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        bus.mem_wr = 1'b1;
        busy       = 1'b1;
        // An abort seen during the write lets the write land, then stops the load.
        if (write_fin) begin
          if (abort || abort_pend)          state_nxt = S_IDLE;
          else if (bus.mem_addr == LAST_ADDR) state_nxt = S_DONE;
          else                              state_nxt = S_LO;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (abort)      state_nxt = S_IDLE;
        else if (start) state_nxt = S_LO;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.mem_addr <= '0;
      bus.mem_d    <= '0;
      checksum     <= '0;
      abort_pend   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start && !abort) begin
            bus.mem_addr <= '0;
            checksum     <= '0;
          end
        end
        S_LO: begin
          if (!abort && bus.rx_valid) bus.mem_d[7:0] <= bus.rx_data;
        end
        S_HI: begin
          if (!abort && bus.rx_valid) bus.mem_d[15:8] <= bus.rx_data;
        end
        S_WRITE: begin
          if (write_fin) begin
            checksum   <= wrap_add16(checksum, bus.mem_d);
            abort_pend <= 1'b0;
            if (state_nxt == S_LO) bus.mem_addr <= bus.mem_addr + 1'b1;
          end else if (abort) begin
            abort_pend <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
